// File: rtl/rtc_sd30xx_seq.sv
// SD30xx RTC sequencer: polls time regs 0x00..0x06, runs unlock/write/lock sets.
// Ports: clk/rstn; set_req/set_time in; time_bcd/time_valid/time_upd/busy/err out;
//        wr_req/rd_req/addr/addr_mode/wr_data/device_id to i2c_control; rd_data/rw_done/ack back.
module rtc_sd30xx_seq #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned POLL_MS  = 100,
    parameter logic [7:0]  DEV_ID   = 8'h64,
    parameter int unsigned TO_CYC   = 2_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        set_req,
    input  logic [55:0] set_time,
    output logic [55:0] time_bcd,
    output logic        time_valid,
    output logic        time_upd,
    output logic        busy,
    output logic        err,
    output logic        wr_req,
    output logic        rd_req,
    output logic [15:0] addr,
    output logic        addr_mode,
    output logic [7:0]  wr_data,
    output logic [7:0]  device_id,
    input  logic [7:0]  rd_data,
    input  logic        rw_done,
    input  logic        ack
);
    localparam int unsigned POLL_CYC  = CLK_FREQ / 1000 * POLL_MS;
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
    localparam logic [31:0] TO_LAST   = 32'(TO_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, RD_ISSUE, RD_WAIT, UNLK_ISSUE, UNLK_WAIT,
        WR_ISSUE, WR_WAIT, LK_ISSUE, LK_WAIT
    } state_t;

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [31:0] poll_cnt, wd_cnt;
    logic        poll_pend, set_pend;
    logic [55:0] set_buf, wr_buf;
    logic [7:0]  shadow [0:5];
    logic [7:0]  reg_a, set_byte;
    logic        in_wait, fin, tout, fail, err_n, upd_n, wrap;

    assign wrap      = (poll_cnt == POLL_LAST);
    assign in_wait   = (state == RD_WAIT) || (state == UNLK_WAIT) ||
                       (state == WR_WAIT) || (state == LK_WAIT);
    assign fin       = in_wait && rw_done;
    assign tout      = in_wait && !rw_done && (wd_cnt == TO_LAST);
    assign fail      = (fin && ack) || tout;
    assign busy      = (state != IDLE);
    assign addr      = {8'h00, reg_a};
    assign addr_mode = 1'b0;
    assign device_id = DEV_ID;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        err_n   = 1'b0;
        upd_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (set_pend) begin
                    state_n = UNLK_ISSUE;
                    idx_n   = 3'd0;
                end else if (poll_pend) begin
                    state_n = RD_ISSUE;
                    idx_n   = 3'd0;
                end
            end
            RD_ISSUE:   state_n = RD_WAIT;
            UNLK_ISSUE: state_n = UNLK_WAIT;
            WR_ISSUE:   state_n = WR_WAIT;
            LK_ISSUE:   state_n = LK_WAIT;
            RD_WAIT: begin
                if (fail) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (fin) begin
                    if (idx == 3'd6) begin
                        upd_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 3'd1;
                        state_n = RD_ISSUE;
                    end
                end
            end
            UNLK_WAIT: begin
                if (fail) begin
                    err_n   = 1'b1;
                    idx_n   = 3'd0;
                    state_n = LK_ISSUE;
                end else if (fin) begin
                    idx_n   = (idx == 3'd1) ? 3'd0 : idx + 3'd1;
                    state_n = (idx == 3'd1) ? WR_ISSUE : UNLK_ISSUE;
                end
            end
            WR_WAIT: begin
                if (fail) begin
                    err_n   = 1'b1;
                    idx_n   = 3'd0;
                    state_n = LK_ISSUE;
                end else if (fin) begin
                    idx_n   = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
                    state_n = (idx == 3'd6) ? LK_ISSUE : WR_ISSUE;
                end
            end
            LK_WAIT: begin
                // a failed lock step still moves on so both lock bytes go out
                err_n = fail;
                if (fin || tout) begin
                    idx_n   = idx + 3'd1;
                    state_n = (idx == 3'd1) ? IDLE : LK_ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        unique case (idx)
            3'd0:    set_byte = wr_buf[7:0];
            3'd1:    set_byte = wr_buf[15:8];
            3'd2:    set_byte = wr_buf[23:16] | 8'h80;
            3'd3:    set_byte = wr_buf[31:24];
            3'd4:    set_byte = wr_buf[39:32];
            3'd5:    set_byte = wr_buf[47:40];
            3'd6:    set_byte = wr_buf[55:48];
            default: set_byte = 8'h00;
        endcase
    end

    always_comb begin
        reg_a   = 8'h00;
        wr_data = 8'h00;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        unique case (state)
            RD_ISSUE, RD_WAIT: begin
                reg_a  = {5'd0, idx};
                rd_req = (state == RD_ISSUE);
            end
            UNLK_ISSUE, UNLK_WAIT: begin
                reg_a   = idx[0] ? 8'h0F : 8'h10;
                wr_data = idx[0] ? 8'h84 : 8'h80;
                wr_req  = (state == UNLK_ISSUE);
            end
            WR_ISSUE, WR_WAIT: begin
                reg_a   = {5'd0, idx};
                wr_data = set_byte;
                wr_req  = (state == WR_ISSUE);
            end
            LK_ISSUE, LK_WAIT: begin
                reg_a  = idx[0] ? 8'h10 : 8'h0F;
                wr_req = (state == LK_ISSUE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            idx        <= 3'd0;
            poll_cnt   <= 32'd0;
            wd_cnt     <= 32'd0;
            poll_pend  <= 1'b0;
            set_pend   <= 1'b0;
            set_buf    <= 56'd0;
            wr_buf     <= 56'd0;
            time_bcd   <= 56'd0;
            time_valid <= 1'b0;
            time_upd   <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 6; i++) shadow[i] <= 8'h00;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            err      <= err_n;
            time_upd <= upd_n;
            poll_cnt <= wrap ? 32'd0 : poll_cnt + 32'd1;
            wd_cnt   <= in_wait ? wd_cnt + 32'd1 : 32'd0;
            if (state == IDLE && state_n == RD_ISSUE) poll_pend <= 1'b0;
            if (wrap) poll_pend <= 1'b1;
            // wr_buf freezes the word for the whole set; set_buf may refill meanwhile
            if (state == IDLE && state_n == UNLK_ISSUE) begin
                set_pend <= 1'b0;
                wr_buf   <= set_buf;
            end
            if (set_req) begin
                set_pend <= 1'b1;
                set_buf  <= set_time;
            end
            if (state == RD_WAIT && fin && !ack && idx < 3'd6)
                shadow[idx] <= rd_data;
            if (upd_n) begin
                time_bcd   <= {rd_data, shadow[5], shadow[4], shadow[3],
                               shadow[2] & 8'h7F, shadow[1], shadow[0]};
                time_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rtc_sd30xx_seq.sv
// Bench for rtc_sd30xx_seq with a small i2c_control responder model.
// Ports: drives clk/rstn/set_req/set_time/rd_data/rw_done/ack; logs every request.
module tb_rtc_sd30xx_seq;
    typedef struct packed {
        logic       wr;
        logic [7:0] rg;
        logic [7:0] dat;
    } tx_t;

    localparam logic [55:0] TA  = 56'h24_01_15_01_08_30_00;
    localparam logic [55:0] TB  = 56'h25_02_28_05_17_45_30;
    localparam logic [55:0] TC  = 56'h11_11_11_11_11_11_11;
    localparam logic [55:0] T1  = 56'h99_12_31_06_23_59_59;
    localparam logic [55:0] T2  = 56'h99_12_31_06_23_59_11;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        set_req = 1'b0;
    logic [55:0] set_time = 56'd0;
    logic [55:0] time_bcd;
    logic        time_valid, time_upd, busy, err, wr_req, rd_req, addr_mode;
    logic [15:0] addr;
    logic [7:0]  wr_data, device_id;
    logic [7:0]  rd_data;
    logic        rw_done, ack;

    logic [7:0]  regs [0:15];
    logic        hold = 1'b0;
    logic        nack_arm = 1'b0;
    logic        nack_wr = 1'b0;
    logic [7:0]  nack_reg = 8'h00;

    logic        tx_wr  [0:2047];
    logic [7:0]  tx_reg [0:2047];
    logic [7:0]  tx_dat [0:2047];
    int          n_tx = 0;
    int          err_cnt = 0;
    int          upd_cnt = 0;
    logic        m_busy, m_nack;
    logic [1:0]  m_lat;
    logic [3:0]  m_reg;

    int n_chk = 0;
    int n_fail = 0;
    tx_t exp_a [11];
    tx_t exp_b [11];

    rtc_sd30xx_seq #(
        .CLK_FREQ(100_000), .POLL_MS(1), .DEV_ID(8'h64), .TO_CYC(40)
    ) dut (
        .clk(clk), .rstn(rstn), .set_req(set_req), .set_time(set_time),
        .time_bcd(time_bcd), .time_valid(time_valid), .time_upd(time_upd),
        .busy(busy), .err(err), .wr_req(wr_req), .rd_req(rd_req),
        .addr(addr), .addr_mode(addr_mode), .wr_data(wr_data),
        .device_id(device_id), .rd_data(rd_data), .rw_done(rw_done), .ack(ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy  <= 1'b0;
            m_nack  <= 1'b0;
            m_lat   <= 2'd0;
            m_reg   <= 4'd0;
            rw_done <= 1'b0;
            ack     <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            rw_done <= 1'b0;
            ack     <= 1'b0;
            if (wr_req || rd_req) begin
                tx_wr[n_tx]  <= wr_req;
                tx_reg[n_tx] <= addr[7:0];
                tx_dat[n_tx] <= wr_data;
                n_tx   <= n_tx + 1;
                m_busy <= 1'b1;
                m_lat  <= 2'd0;
                m_reg  <= addr[3:0];
                m_nack <= nack_arm && (nack_wr == wr_req) && (nack_reg == addr[7:0]);
            end else if (m_busy && !hold) begin
                if (m_lat == 2'd2) begin
                    m_busy  <= 1'b0;
                    rw_done <= 1'b1;
                    ack     <= m_nack;
                    rd_data <= regs[m_reg];
                end else begin
                    m_lat <= m_lat + 2'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (time_upd) upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_rd(input string nm, input int k, input int r);
        chk(nm, {55'd0, tx_wr[k], tx_reg[k]}, {55'd0, 1'b0, 8'(r)});
    endtask

    task automatic chk_wr(input string nm, input int k, input tx_t e);
        chk(nm, {47'd0, tx_wr[k], tx_reg[k], tx_dat[k]}, {47'd0, e});
    endtask

    initial begin
        int n0, n1, e0, u0;
        exp_a[0]  = '{1'b1, 8'h10, 8'h80};
        exp_a[1]  = '{1'b1, 8'h0F, 8'h84};
        exp_a[2]  = '{1'b1, 8'h00, 8'h00};
        exp_a[3]  = '{1'b1, 8'h01, 8'h30};
        exp_a[4]  = '{1'b1, 8'h02, 8'h88};
        exp_a[5]  = '{1'b1, 8'h03, 8'h01};
        exp_a[6]  = '{1'b1, 8'h04, 8'h15};
        exp_a[7]  = '{1'b1, 8'h05, 8'h01};
        exp_a[8]  = '{1'b1, 8'h06, 8'h24};
        exp_a[9]  = '{1'b1, 8'h0F, 8'h00};
        exp_a[10] = '{1'b1, 8'h10, 8'h00};
        exp_b = exp_a;
        exp_b[2]  = '{1'b1, 8'h00, 8'h30};
        exp_b[3]  = '{1'b1, 8'h01, 8'h45};
        exp_b[4]  = '{1'b1, 8'h02, 8'h97};
        exp_b[5]  = '{1'b1, 8'h03, 8'h05};
        exp_b[6]  = '{1'b1, 8'h04, 8'h28};
        exp_b[7]  = '{1'b1, 8'h05, 8'h02};
        exp_b[8]  = '{1'b1, 8'h06, 8'h25};
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[0] = 8'h59; regs[1] = 8'h59; regs[2] = 8'hA3; regs[3] = 8'h06;
        regs[4] = 8'h31; regs[5] = 8'h12; regs[6] = 8'h99;

        repeat (3) @(negedge clk);
        chk("rst_time_bcd", time_bcd, 0);
        chk("rst_time_valid", time_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", {wr_req, rd_req, err, time_upd}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dev_id", {addr_mode, device_id}, 9'h064);
        rstn = 1'b1;

        // first poll burst
        for (int c = 0; c < 400 && upd_cnt == 0; c++) @(negedge clk);
        chk("burst1_upd", upd_cnt, 1);
        chk("burst1_ntx", n_tx, 7);
        for (int i = 0; i < 7; i++) chk_rd($sformatf("burst1_rd%0d", i), i, i);
        chk("burst1_time", time_bcd, T1);
        chk("burst1_valid", time_valid, 1);
        chk("burst1_err", err_cnt, 0);

        // clean set sequence
        set_time = TA; set_req = 1'b1;
        @(negedge clk) set_req = 1'b0;
        n0 = n_tx;
        for (int c = 0; c < 200 && !(n_tx >= n0 + 11 && !busy); c++) @(negedge clk);
        chk("set_ntx", n_tx - n0, 11);
        for (int i = 0; i < 11; i++) chk_wr($sformatf("set_tx%0d", i), n0 + i, exp_a[i]);
        chk("set_err", err_cnt, 0);

        // NACK on read idx 3
        u0 = upd_cnt;
        for (int c = 0; c < 300 && upd_cnt == u0; c++) @(negedge clk);
        chk("pre_nack_upd", upd_cnt, u0 + 1);
        regs[0] = 8'h11; nack_arm = 1'b1; nack_wr = 1'b0; nack_reg = 8'h03;
        n0 = n_tx; e0 = err_cnt; u0 = upd_cnt;
        for (int c = 0; c < 300 && err_cnt == e0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        nack_arm = 1'b0;
        chk("rdnack_err", err_cnt, e0 + 1);
        chk("rdnack_upd", upd_cnt, u0);
        chk("rdnack_time", time_bcd, T1);
        chk("rdnack_ntx", n_tx - n0, 4);
        for (int i = 0; i < 4; i++) chk_rd($sformatf("rdnack_rd%0d", i), n0 + i, i);
        n1 = n_tx;
        for (int c = 0; c < 300 && upd_cnt == u0; c++) @(negedge clk);
        chk("retry_upd", upd_cnt, u0 + 1);
        for (int i = 0; i < 7; i++) chk_rd($sformatf("retry_rd%0d", i), n1 + i, i);
        chk("retry_time", time_bcd, T2);

        // NACK on write of reg 0x02
        nack_arm = 1'b1; nack_wr = 1'b1; nack_reg = 8'h02;
        set_time = TA; set_req = 1'b1;
        @(negedge clk) set_req = 1'b0;
        n0 = n_tx; e0 = err_cnt;
        for (int c = 0; c < 300 && err_cnt == e0; c++) @(negedge clk);
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        nack_arm = 1'b0;
        chk("wrnack_err", err_cnt, e0 + 1);
        chk("wrnack_ntx", n_tx - n0, 7);
        for (int i = 0; i < 5; i++) chk_wr($sformatf("wrnack_tx%0d", i), n0 + i, exp_a[i]);
        chk_wr("wrnack_lk0", n0 + 5, exp_a[9]);
        chk_wr("wrnack_lk1", n0 + 6, exp_a[10]);

        // watchdog on a held read
        hold = 1'b1; e0 = err_cnt; u0 = upd_cnt;
        for (int c = 0; c < 300 && err_cnt == e0; c++) @(negedge clk);
        chk("wd_err", err_cnt, e0 + 1);
        chk("wd_idle", busy, 0);
        chk("wd_is_read", tx_wr[n_tx - 1], 0);
        hold = 1'b0;
        repeat (8) @(negedge clk);
        chk("stale_done_ignored", {31'd0, busy, upd_cnt}, {31'd0, 1'b0, u0});
        chk("wd_time", time_bcd, T2);

        // reset mid-write
        set_time = TA; set_req = 1'b1;
        @(negedge clk) set_req = 1'b0;
        n0 = n_tx;
        for (int c = 0; c < 100 && n_tx < n0 + 4; c++) @(negedge clk);
        chk("midwr_reached", n_tx - n0, 4);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_req", {wr_req, rd_req, err, time_upd}, 0);
        chk("midrst_addr", {addr, wr_data}, 0);
        chk("midrst_time", {time_valid, time_bcd}, 0);
        chk("midrst_dev", device_id, 8'h64);
        repeat (3) @(negedge clk);

        // set_req coincident with a poll wrap, then last-wins set mid-burst
        rstn = 1'b1;
        n0 = n_tx; e0 = err_cnt;
        repeat (99) @(posedge clk);
        @(negedge clk);
        set_time = TA; set_req = 1'b1;
        @(negedge clk) set_req = 1'b0;
        for (int c = 0; c < 200 && n_tx < n0 + 12; c++) @(negedge clk);
        set_time = TC; set_req = 1'b1;
        @(negedge clk) set_time = TB;
        @(negedge clk) set_req = 1'b0;
        for (int c = 0; c < 400 && n_tx < n0 + 29; c++) @(negedge clk);
        chk("seq5_ntx", n_tx >= n0 + 29, 1);
        for (int i = 0; i < 11; i++) chk_wr($sformatf("seq5_a%0d", i), n0 + i, exp_a[i]);
        for (int i = 0; i < 7; i++) chk_rd($sformatf("seq5_rd%0d", i), n0 + 11 + i, i);
        for (int i = 0; i < 11; i++) chk_wr($sformatf("seq5_b%0d", i), n0 + 18 + i, exp_b[i]);
        chk("seq5_err", err_cnt, e0);
        chk("seq5_time", {time_valid, time_bcd}, {1'b1, T2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
